vga_fb_scanout: RTL



---
 rtl/vga_fb_scanout.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_fb_scanout: VGA timing + banked byte framebuffer scan-out, with a      |
// | framed serial command port that writes bytes into the banks.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_fb_scanout #(
  parameter int HVIS    = 256,
  parameter int HFP     = 6,
  parameter int HSW     = 39,
  parameter int HT      = 320,
  parameter int VVIS    = 480,
  parameter int VFP     = 10,
  parameter int VSW     = 2,
  parameter int VT      = 525,
  parameter int BPP     = 4,
  parameter int NBANK   = 8,
  parameter int BANK_AW = 8,
  parameter int X0      = 64,
  parameter int Y0      = 0,
  parameter int FB_W    = 128,
  parameter int FB_H    = 112,
  parameter int YSHIFT  = 1,
  parameter int WE_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_cs,
  input  logic                   serial_clk,
  input  logic                   serial_data,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [BPP-1:0]         pix,
  output logic                   frame_start,
  output logic [BANK_AW-1:0]     bank_rd_addr,
  input  logic [8*NBANK-1:0]     bank_rd_data,
  output logic [BANK_AW-1:0]     bank_wr_addr,
  output logic [7:0]             bank_wr_data,
  output logic [NBANK-1:0]       bank_we,
  output logic                   busy,
  output logic                   overrun
);

  localparam int c_NBW  = $clog2(NBANK);
  localparam int c_AW   = BANK_AW + c_NBW;
  localparam int c_PPB  = 8 / BPP;
  localparam int c_SUBW = (c_PPB > 1) ? $clog2(c_PPB) : 1;
  localparam int c_HCW  = $clog2(HT);
  localparam int c_VCW  = $clog2(VT);
  localparam int c_WCW  = (WE_CYC > 1) ? $clog2(WE_CYC) : 1;
  localparam logic [NBANK-1:0] c_ONE = NBANK'(1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_IGNORE} cmd_state_t;
  typedef enum logic [1:0] {WS_IDLE, WS_SETUP, WS_PULSE, WS_HOLD} wr_state_t;

  logic [c_HCW-1:0]   r_hcnt;
  logic [c_VCW-1:0]   r_vcnt;
  logic               r_fs;
  logic               w_hlast, w_vlast;

  logic [31:0]        w_hc, w_vc, w_x, w_y, w_p, w_a;
  logic               w_in, w_hs_n, w_vs_n, w_vis;

  logic [BANK_AW-1:0] r_rd_addr;
  logic [c_NBW-1:0]   r_bank_s1, r_bank_s2;
  logic [c_SUBW-1:0]  r_sub_s1, r_sub_s2;
  logic               r_in_s1, r_in_s2, r_de_s1, r_de_s2, r_de_s3;
  logic               r_hs_s1, r_hs_s2, r_hs_s3, r_vs_s1, r_vs_s2, r_vs_s3;
  logic [BPP-1:0]     r_pix;
  logic [8*NBANK-1:0] w_bank_sh;
  logic [7:0]         w_pix_sh;

  logic               r_cs_m, r_cs_s, r_cs_d, r_sck_m, r_sck_s, r_sck_d, r_sd_m, r_sd_s;
  logic [6:0]         r_shift;
  logic [2:0]         r_bitcnt;
  logic               w_sck_rise, w_cs_rise, w_byte_done;
  logic [7:0]         w_byte;

  cmd_state_t         r_state;
  wr_state_t          r_wstate;
  logic [c_AW-1:0]    r_addr;
  logic [7:0]         r_addr_h;
  logic [c_NBW-1:0]   r_wbank;
  logic [c_WCW-1:0]   r_wcnt;
  logic [NBANK-1:0]   r_we;
  logic [BANK_AW-1:0] r_wr_addr;
  logic [7:0]         r_wr_data;
  logic               r_busy, r_overrun;
  logic               w_unused;

  // ---------------- timing counters ----------------
  assign w_hlast = (r_hcnt == c_HCW'(HT - 1));
  assign w_vlast = (r_vcnt == c_VCW'(VT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_fs   <= 1'b0;
    end else begin
      // Registered from the wrap so the pulse coincides with counters at (0,0)
      r_fs <= w_hlast && w_vlast;
      if (w_hlast) begin
        r_hcnt <= '0;
        r_vcnt <= w_vlast ? '0 : r_vcnt + c_VCW'(1);
      end else begin
        r_hcnt <= r_hcnt + c_HCW'(1);
      end
    end
  end

  always_comb begin
    w_hc   = 32'(r_hcnt);
    w_vc   = 32'(r_vcnt);
    w_x    = w_hc - 32'(X0);
    w_y    = (w_vc - 32'(Y0)) >> YSHIFT;
    w_in   = (w_hc >= 32'(X0)) && (w_hc < 32'(X0 + FB_W)) &&
             (w_vc >= 32'(Y0)) && (w_y < 32'(FB_H));
    w_p    = w_y * 32'(FB_W) + w_x;
    w_a    = (w_p * 32'(BPP)) >> 3;
    w_hs_n = !((w_hc >= 32'(HVIS + HFP)) && (w_hc < 32'(HVIS + HFP + HSW)));
    w_vs_n = !((w_vc >= 32'(VVIS + VFP)) && (w_vc < 32'(VVIS + VFP + VSW)));
    w_vis  = (w_hc < 32'(HVIS)) && (w_vc < 32'(VVIS));
  end

  assign w_bank_sh = bank_rd_data >> {r_bank_s2, 3'b000};
  assign w_pix_sh  = w_bank_sh[7:0] >> (32'(r_sub_s2) * 32'(BPP));
  assign w_unused  = &{1'b0, w_a, w_p, w_bank_sh, w_pix_sh};

  // ---------------- scan-out pipeline ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_bank_s1 <= '0;  r_bank_s2 <= '0;
      r_sub_s1  <= '0;  r_sub_s2  <= '0;
      r_in_s1   <= 1'b0; r_in_s2  <= 1'b0;
      r_de_s1   <= 1'b0; r_de_s2  <= 1'b0; r_de_s3 <= 1'b0;
      r_hs_s1   <= 1'b1; r_hs_s2  <= 1'b1; r_hs_s3 <= 1'b1;
      r_vs_s1   <= 1'b1; r_vs_s2  <= 1'b1; r_vs_s3 <= 1'b1;
      r_pix     <= '0;
    end else begin
      r_rd_addr <= w_a[BANK_AW-1:0];
      r_bank_s1 <= w_a[c_AW-1:BANK_AW];
      r_sub_s1  <= c_SUBW'(w_p % 32'(c_PPB));
      r_in_s1   <= w_in;
      r_de_s1   <= w_vis;
      r_hs_s1   <= w_hs_n;
      r_vs_s1   <= w_vs_n;
      r_bank_s2 <= r_bank_s1;
      r_sub_s2  <= r_sub_s1;
      r_in_s2   <= r_in_s1;
      r_de_s2   <= r_de_s1;
      r_hs_s2   <= r_hs_s1;
      r_vs_s2   <= r_vs_s1;
      r_de_s3   <= r_de_s2;
      r_hs_s3   <= r_hs_s2;
      r_vs_s3   <= r_vs_s2;
      r_pix     <= (r_in_s2 && r_de_s2) ? w_pix_sh[BPP-1:0] : '0;
    end
  end

  // ---------------- serial receiver ----------------
  assign w_sck_rise  = r_sck_s & ~r_sck_d;
  assign w_cs_rise   = r_cs_s & ~r_cs_d;
  assign w_byte_done = r_cs_s && w_sck_rise && (r_bitcnt == 3'd7);
  assign w_byte      = {r_shift, r_sd_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_m  <= 1'b0; r_cs_s  <= 1'b0; r_cs_d  <= 1'b0;
      r_sck_m <= 1'b0; r_sck_s <= 1'b0; r_sck_d <= 1'b0;
      r_sd_m  <= 1'b0; r_sd_s  <= 1'b0;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_cs_m  <= serial_cs;   r_cs_s  <= r_cs_m;  r_cs_d  <= r_cs_s;
      r_sck_m <= serial_clk;  r_sck_s <= r_sck_m; r_sck_d <= r_sck_s;
      r_sd_m  <= serial_data; r_sd_s  <= r_sd_m;
      if (!r_cs_s) begin
        r_bitcnt <= '0;
      end else if (w_sck_rise) begin
        r_shift  <= {r_shift[5:0], r_sd_s};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end

  // ---------------- command FSM and write sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wstate  <= WS_IDLE;
      r_addr    <= '0;
      r_addr_h  <= '0;
      r_wbank   <= '0;
      r_wcnt    <= '0;
      r_we      <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_wstate)
        WS_SETUP: begin
          r_wstate <= WS_PULSE;
          r_we     <= c_ONE << r_wbank;
          r_wcnt   <= '0;
        end
        WS_PULSE: begin
          if (r_wcnt == c_WCW'(WE_CYC - 1)) begin
            r_we     <= '0;
            r_wstate <= WS_HOLD;
          end else begin
            r_wcnt <= r_wcnt + c_WCW'(1);
          end
        end
        WS_HOLD: begin
          r_wstate <= WS_IDLE;
          r_busy   <= 1'b0;
          r_addr   <= r_addr + c_AW'(1);
        end
        default: ;
      endcase

      // Losing cs only aborts the command layer; a launched write runs to completion
      if (!r_cs_s) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:   if (w_cs_rise) r_state <= S_CMD;
          S_IGNORE: ;
          default: begin
            if (w_byte_done) begin
              if (r_busy) begin
                r_overrun <= 1'b1;
              end else begin
                case (r_state)
                  S_CMD: begin
                    if (w_byte == 8'h01)      r_state <= S_ADDR_H;
                    else if (w_byte == 8'h02) r_state <= S_DATA;
                    else                      r_state <= S_IGNORE;
                  end
                  S_ADDR_H: begin
                    r_addr_h <= w_byte;
                    r_state  <= S_ADDR_L;
                  end
                  S_ADDR_L: begin
                    r_addr  <= c_AW'({r_addr_h, w_byte});
                    r_state <= S_CMD;
                  end
                  S_DATA: begin
                    r_wstate  <= WS_SETUP;
                    r_busy    <= 1'b1;
                    r_wr_addr <= r_addr[BANK_AW-1:0];
                    r_wbank   <= r_addr[c_AW-1:BANK_AW];
                    r_wr_data <= w_byte;
                  end
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign hsync        = r_hs_s3;
  assign vsync        = r_vs_s3;
  assign de           = r_de_s3;
  assign pix          = r_pix;
  assign frame_start  = r_fs;
  assign bank_rd_addr = r_rd_addr;
  assign bank_wr_addr = r_wr_addr;
  assign bank_wr_data = r_wr_data;
  assign bank_we      = r_we;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
